// File: rtl/chacha_bus_if_if.sv
// Word-addressed 32-bit register bus between a host master and the ChaCha register block.
// read_data is registered by the slave and follows a read strobe by one cycle.
interface chacha_bus_if_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  write;
  logic [31:0]           write_data;
  logic                  read;
  logic [31:0]           read_data;
  logic [ADDR_WIDTH-1:0] addr;

  modport master (output write, output write_data, output read, output addr, input read_data);
  modport slave  (input write, input write_data, input read, input addr, output read_data);
endinterface

// File: rtl/chacha_bus_if.sv
// Register front-end for the ChaCha core: config/key/data registers, init/next pulses,
// completion tracking FSM and a captured 512-bit result bank.
module chacha_bus_if #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter logic [4:0]  DEFAULT_ROUNDS = 5'd20,
  parameter logic        DEFAULT_KEYLEN = 1'b1,
  parameter logic [31:0] CORE_VERSION   = 32'h00010000
) (
  input  logic           clk,
  input  logic           reset_n,
  chacha_bus_if_if.slave bus,
  output logic           core_init,
  output logic           core_next,
  output logic [255:0]   core_key,
  output logic           core_keylen,
  output logic [4:0]     core_rounds,
  output logic [63:0]    core_iv,
  output logic [63:0]    core_ctr,
  output logic [511:0]   core_data_in,
  input  logic           core_ready,
  input  logic [511:0]   core_data_out,
  input  logic           core_data_out_valid,
  output logic           irq
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StCapture} state_e;

  state_e r_state, w_state_next;

  logic [31:0] r_key      [8];
  logic [31:0] r_iv       [2];
  logic [31:0] r_data_in  [16];
  logic [31:0] r_data_out [16];
  logic [31:0] r_ctr_lo, r_ctr_hi, r_read_data, w_rdata;
  logic [4:0]  r_rounds;
  logic        r_keylen, r_auto_inc, r_ie, r_done, r_err, r_is_init;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_a;
  logic [31:0]           w_wd;
  logic w_hit, w_wr, w_wr_ctrl, w_wr_status, w_req, w_start, w_lockable;
  logic w_lock_err, w_wait_fail, w_capture, w_busy;

  // Any address bit above bit 7 makes the access unmapped.
  assign w_addr      = bus.addr;
  assign w_a         = w_addr[7:0];
  assign w_hit       = (w_addr >> 8) == '0;
  assign w_wd        = bus.write_data;
  assign w_busy      = r_state != StIdle;
  assign w_wr        = bus.write & w_hit;
  assign w_wr_ctrl   = w_wr & (w_a == 8'h08);
  assign w_wr_status = w_wr & (w_a == 8'h09);
  assign w_req       = w_wr_ctrl & (w_wd[0] | w_wd[1]);
  assign w_start     = w_req & ~w_busy;
  assign w_lockable  = w_wr & ((w_a == 8'h0A) | (w_a == 8'h0B) | (w_a[7:3] == 5'b00010) |
                               (w_a[7:2] == 6'b001000) | (w_a[7:4] == 4'h4));
  assign w_lock_err  = w_busy & (w_lockable | w_req);
  assign w_wait_fail = (r_state == StWait) & core_ready & ~core_data_out_valid;
  assign w_capture   = r_state == StCapture;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:    if (w_start) w_state_next = StStart;
      StStart:   w_state_next = StWait;
      StWait:    if (core_ready) w_state_next = core_data_out_valid ? StCapture : StIdle;
      StCapture: w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++)  r_key[i] <= '0;
      for (int i = 0; i < 16; i++) r_data_in[i] <= '0;
      for (int i = 0; i < 16; i++) r_data_out[i] <= '0;
      r_iv[0]     <= '0;
      r_iv[1]     <= '0;
      r_ctr_lo    <= '0;
      r_ctr_hi    <= '0;
      r_keylen    <= DEFAULT_KEYLEN;
      r_rounds    <= DEFAULT_ROUNDS;
      r_auto_inc  <= 1'b0;
      r_ie        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_is_init   <= 1'b0;
      r_read_data <= '0;
    end else begin
      if (w_wr & ~w_busy) begin
        if (w_a[7:3] == 5'b00010) r_key[w_a[2:0]] <= w_wd;
        if (w_a[7:4] == 4'h4)     r_data_in[w_a[3:0]] <= w_wd;
        if (w_a == 8'h20)         r_iv[0] <= w_wd;
        if (w_a == 8'h21)         r_iv[1] <= w_wd;
        if (w_a == 8'h22)         r_ctr_lo <= w_wd;
        if (w_a == 8'h23)         r_ctr_hi <= w_wd;
        if (w_a == 8'h0A)         r_keylen <= w_wd[0];
        if (w_a == 8'h0B)         r_rounds <= w_wd[4:0];
      end
      if (w_wr_ctrl) begin
        r_auto_inc <= w_wd[2];
        r_ie       <= w_wd[3];
      end
      if (w_start) r_is_init <= w_wd[0];
      // Completion beats a same-cycle W1C.
      if (w_capture) r_done <= 1'b1;
      else if (w_start || (w_wr_status && w_wd[1])) r_done <= 1'b0;
      if (w_lock_err || w_wait_fail) r_err <= 1'b1;
      else if (w_wr_status && w_wd[3]) r_err <= 1'b0;
      if (w_capture) begin
        for (int i = 0; i < 16; i++) r_data_out[i] <= core_data_out[511-32*i -: 32];
        if (r_auto_inc) {r_ctr_hi, r_ctr_lo} <= {r_ctr_hi, r_ctr_lo} + 64'd1;
      end
      r_read_data <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.read && w_hit) begin
      if (w_a[7:3] == 5'b00010)  w_rdata = r_key[w_a[2:0]];
      else if (w_a[7:4] == 4'h4) w_rdata = r_data_in[w_a[3:0]];
      else if (w_a[7:4] == 4'h8) w_rdata = r_data_out[w_a[3:0]];
      else begin
        case (w_a)
          8'h00:   w_rdata = 32'h63686163;
          8'h01:   w_rdata = 32'h68613230;
          8'h02:   w_rdata = CORE_VERSION;
          8'h08:   w_rdata = {28'd0, r_ie, r_auto_inc, 2'b00};
          8'h09:   w_rdata = {28'd0, r_err, w_busy, r_done, core_ready};
          8'h0A:   w_rdata = {31'd0, r_keylen};
          8'h0B:   w_rdata = {27'd0, r_rounds};
          8'h20:   w_rdata = r_iv[0];
          8'h21:   w_rdata = r_iv[1];
          8'h22:   w_rdata = r_ctr_lo;
          8'h23:   w_rdata = r_ctr_hi;
          default: w_rdata = '0;
        endcase
      end
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_key
    assign core_key[255-32*g -: 32] = r_key[g];
  end
  for (genvar g = 0; g < 16; g++) begin : g_din
    assign core_data_in[511-32*g -: 32] = r_data_in[g];
  end

  assign core_init     = (r_state == StStart) & r_is_init;
  assign core_next     = (r_state == StStart) & ~r_is_init;
  assign core_iv       = {r_iv[0], r_iv[1]};
  assign core_ctr      = {r_ctr_hi, r_ctr_lo};
  assign core_keylen   = r_keylen;
  assign core_rounds   = r_rounds;
  assign irq           = r_done & r_ie;
  assign bus.read_data = r_read_data;

endmodule
